// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: accepts one load/store at a time, stalls the
// initiator for LATENCY cycles, steers sub-word lanes and flags bad requests.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_dmem_addr,
  input  logic [31:0] i_dmem_wdata,
  input  logic [1:0]  i_dmem_wr_type,
  input  logic [2:0]  i_dmem_rd_type,
  input  logic        i_dmem_wr_en,
  input  logic        i_dmem_rd_en,
  output logic [31:0] o_dmem_rdata,
  output logic        o_dmem_ack,
  output logic        o_dmem_err,
  output logic        o_dmem_stall
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  wr_type_q;
  logic [2:0]  rd_type_q;
  logic        is_wr_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  // Request view: live inputs while idle (needed when LATENCY=0), captured copy otherwise
  logic        idle;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_wr_type;
  logic [2:0]  req_rd_type;
  logic        req_is_wr;

  logic [31:0] offset;
  logic        in_range, type_err, req_err, commit, mem_we;
  logic [AW-1:0] idx;
  logic [1:0]  lane;
  logic [31:0] word, load_data, st_data;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [3:0]  st_be;

  assign idle        = (state_q == StIdle);
  assign req_addr    = idle ? i_dmem_addr    : addr_q;
  assign req_wdata   = idle ? i_dmem_wdata   : wdata_q;
  assign req_wr_type = idle ? i_dmem_wr_type : wr_type_q;
  assign req_rd_type = idle ? i_dmem_rd_type : rd_type_q;
  assign req_is_wr   = idle ? i_dmem_wr_en   : is_wr_q;

  assign offset   = req_addr - BASE_ADDR;
  assign in_range = offset < SPAN;
  assign idx      = offset[AW+1:2];
  assign lane     = req_addr[1:0];

  // Next-state and wait counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (i_dmem_wr_en | i_dmem_rd_en) begin
          if (LATENCY > 0) begin
            state_d = StWait;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = StResp;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StResp;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // RESP is only entered from IDLE/WAIT, so this marks the commit edge
  assign commit = (state_d == StResp);

  // Type/alignment checks on the request view
  always_comb begin
    type_err = 1'b0;
    if (req_is_wr) begin
      unique case (req_wr_type)
        2'b00:   type_err = 1'b0;
        2'b01:   type_err = req_addr[0];
        2'b10:   type_err = (lane != 2'b00);
        default: type_err = 1'b1;
      endcase
    end else begin
      unique case (req_rd_type)
        3'b000, 3'b100: type_err = 1'b0;
        3'b001, 3'b101: type_err = req_addr[0];
        3'b010:         type_err = (lane != 2'b00);
        default:        type_err = 1'b1;
      endcase
    end
  end

  assign req_err = ~in_range | type_err;

  // Load lane selection and extension
  assign word     = mem[idx];
  assign sel_byte = word[{lane, 3'b000} +: 8];
  assign sel_half = req_addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    load_data = 32'd0;
    unique case (req_rd_type)
      3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b010:  load_data = word;
      3'b100:  load_data = {24'd0, sel_byte};
      3'b101:  load_data = {16'd0, sel_half};
      default: load_data = 32'd0;
    endcase
  end

  // Store lane steering: replicate data across lanes, pick lanes with byte enables
  always_comb begin
    st_be   = 4'b0000;
    st_data = req_wdata;
    unique case (req_wr_type)
      2'b00: begin
        st_be   = 4'b0001 << lane;
        st_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_be   = req_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{req_wdata[15:0]}};
      end
      2'b10:   st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
  end

  // Writes are gated by rst so a reset edge can never commit a store
  assign mem_we = commit & req_is_wr & ~req_err & rst;

  // Storage: no reset, contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  // FSM state, counter, request capture and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      wr_type_q <= 2'd0;
      rd_type_q <= 3'd0;
      is_wr_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (idle && (i_dmem_wr_en | i_dmem_rd_en)) begin
        addr_q    <= i_dmem_addr;
        wdata_q   <= i_dmem_wdata;
        wr_type_q <= i_dmem_wr_type;
        rd_type_q <= i_dmem_rd_type;
        is_wr_q   <= i_dmem_wr_en;
      end
      err_q   <= commit & req_err;
      rdata_q <= (commit & ~req_err & ~req_is_wr) ? load_data : 32'd0;
    end
  end

  assign o_dmem_ack   = (state_q == StResp);
  assign o_dmem_err   = err_q;
  assign o_dmem_rdata = rdata_q;
  assign o_dmem_stall = (i_dmem_wr_en | i_dmem_rd_en) & ~o_dmem_ack;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Wait-state data-memory responder: the target end of the pipeline's dmem request interface (addr/wdata/wr_type/rd_type/wr_en/rd_en).
- Accepts one load or store at a time and holds the initiator with a stall signal for a programmable latency.
- Performs RISC-V sub-word lane steering, zero/sign extension and alignment/range checking.
- Completes each request with a one-cycle ack, with an error flag when the request is rejected.

Parameters:
- DEPTH_WORDS, 1024, storage depth in 32-bit words; power of two.
- LATENCY, 2, wait cycles between acceptance and completion; legal range 0..15.
- BASE_ADDR, 32'h0000_2000, byte address of word 0; must be 4-byte aligned.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- i_dmem_addr  input  32  byte address.
- i_dmem_wdata  input  32  store data; byte/half data in the low bits.
- i_dmem_wr_type  input  2  store width: 00 SB, 01 SH, 10 SW, 11 reserved.
- i_dmem_rd_type  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others reserved.
- i_dmem_wr_en  input  1  store request, level; held until ack.
- i_dmem_rd_en  input  1  load request, level; held until ack.
- o_dmem_rdata  output  32  extended load data; valid while o_dmem_ack=1.
- o_dmem_ack  output  1  one-cycle completion pulse.
- o_dmem_err  output  1  asserted with ack when the request was rejected.
- o_dmem_stall  output  1  combinational: (i_dmem_wr_en | i_dmem_rd_en) & ~o_dmem_ack.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, counter=0.
  - o_dmem_rdata=0, o_dmem_ack=0, o_dmem_err=0.
  - Any pending request is dropped; storage contents are not initialised and not modified.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with wr_en|rd_en=1, capture addr, wdata, types and direction.
  - If wr_en and rd_en are both 1, the store wins and the load is ignored.
  - Next state: WAIT with counter=LATENCY-1 if LATENCY>0; otherwise RESP.
- WAIT: counter decrements each edge; at counter==0 the next state is RESP.
- Commit edge (the edge entering RESP):
  - Memory is written, or read data is registered.
  - o_dmem_ack=1 for exactly the RESP cycle.
  - Ack is visible in the cycle after edge N+LATENCY, where N is the accepting edge.
- RESP: returns to IDLE unconditionally. Requests are accepted only in IDLE, so back-to-back requests see one idle bubble.
- Stall: o_dmem_stall is high for every cycle a request is present, except the ack cycle.
- Decode:
  - offset = captured_addr - BASE_ADDR (32-bit unsigned).
  - In range iff offset < DEPTH_WORDS*4.
  - Word index = offset[log2(DEPTH_WORDS)+1:2].
- Error conditions (checked on captured values): out of range; reserved type code; SH/LH/LHU with addr[0]=1; SW/LW with addr[1:0]!=0.
- Error response: ack=1, err=1, rdata=0, no storage write. Latency is identical to a good request.
- Store lane steering:
  - SB writes byte lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0}+1..0 with wdata[15:0].
  - SW writes all four lanes.
  - Unselected lanes are unchanged.
- Load extension:
  - LB/LH sign-extend the selected byte/half to 32 bits.
  - LBU/LHU zero-extend.
  - LW returns the full word.
- Store completion: rdata=0 on the store ack cycle.
- Read-after-write: a load accepted after a store's ack returns the stored data.
- Input changes: changes to inputs after acceptance are ignored until the next IDLE acceptance.

Test Plan:
- Reset, LATENCY=2: SW addr 0x2000, wdata 0xDEADBEEF → stall high 3 cycles, ack+!err in the cycle after edge N+2. Then LW 0x2000 → rdata 0xDEADBEEF.
- Sub-word store/load: SB 0x2001, wdata 0x80; then LB 0x2001 → 0xFFFFFF80; LBU 0x2001 → 0x00000080. SH 0x2006, wdata 0x1234; then LW 0x2004 → upper half 0x1234, lower half unchanged.
- Errors:
  - LW 0x2002 (misaligned) → ack+err, rdata 0.
  - SW 0x1FFC (below base) → ack+err; subsequent LW 0x1FFC still errors.
  - SW at base+DEPTH_WORDS*4 → ack+err, memory unchanged.
  - rd_type 011 → ack+err.
- Simultaneous: wr_en=rd_en=1, SW 0x2010, wdata 0xA5A5A5A5 → a single ack, rdata 0. A following LW 0x2010 → 0xA5A5A5A5.
- LATENCY=0 back-to-back: two loads held continuously → acks spaced 2 cycles apart (accept, RESP, IDLE bubble); stall low only on ack cycles.
- Mid-operation reset: rst=0 while in WAIT of SW 0x2020, 0x11111111 → ack never asserts and outputs are 0. After release, LW 0x2020 returns its old value (not 0x11111111).
